// File: rtl/flash_sample_fetcher.sv
// flash_sample_fetcher
//   Streams 16-bit audio samples out of 32-bit flash words. An Avalon-MM read
//   master fetches one word at a time. The two half-words are then released
//   one per sample tick, in an order chosen by the playback direction.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   sample_freq_div [31:0]   sample period in clk cycles (0 and 1 act as 2)
//   pause                    freezes the tick counter and the sample output
//   forward                  1 = ascending word addresses, 0 = descending
//   fetcher_reset            pulse: restart at the image start for the direction
//   flash_mem_*              Avalon-MM read master (read, address, waitrequest,
//                            readdata, readdatavalid)
//   audio_data [15:0]        current sample, held between ticks
//   audio_valid              one-cycle pulse when audio_data updates
//   underrun                 one-cycle pulse when a tick finds no sample ready
module flash_sample_fetcher #(
  parameter int unsigned          ADDR_W    = 23,
  parameter logic [ADDR_W-1:0]    LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       sample_freq_div,
  input  logic              pause,
  input  logic              forward,
  input  logic              fetcher_reset,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              underrun
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    SLOT0,
    SLOT1
  } state_t;

  state_t            state, state_n;
  logic [31:0]       cnt, cnt_n;
  logic [31:0]       div_eff;
  logic              tick;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       word, word_n;
  logic              word_fwd, word_fwd_n;
  logic              rst_pend, rst_pend_n;
  logic              restart;
  logic              read_n;
  logic [15:0]       audio_data_n;
  logic              audio_valid_n;
  logic              underrun_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      word              <= '0;
      word_fwd          <= 1'b0;
      rst_pend          <= 1'b0;
      flash_mem_read    <= 1'b0;
      flash_mem_address <= '0;
      audio_data        <= '0;
      audio_valid       <= 1'b0;
      underrun          <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      word              <= word_n;
      word_fwd          <= word_fwd_n;
      rst_pend          <= rst_pend_n;
      flash_mem_read    <= read_n;
      flash_mem_address <= addr_n;
      audio_data        <= audio_data_n;
      audio_valid       <= audio_valid_n;
      underrun          <= underrun_n;
    end
  end

  always_comb begin
    div_eff = (sample_freq_div < 32'd2) ? 32'd2 : sample_freq_div;
    // Compare against the live divider so a shrinking period never waits
    // for the counter to overflow.
    tick    = !pause && (cnt >= div_eff - 32'd1);

    state_n       = state;
    cnt_n         = pause ? cnt : (tick ? '0 : cnt + 32'd1);
    addr_n        = flash_mem_address;
    word_n        = word;
    word_fwd_n    = word_fwd;
    rst_pend_n    = rst_pend;
    restart       = 1'b0;
    audio_data_n  = audio_data;
    audio_valid_n = 1'b0;
    underrun_n    = 1'b0;

    case (state)
      IDLE: begin
        underrun_n = tick;
        state_n    = REQ;
        restart    = fetcher_reset;
      end
      REQ: begin
        underrun_n = tick;
        if (fetcher_reset) rst_pend_n = 1'b1;
        if (!flash_mem_waitrequest) state_n = WAIT_DATA;
      end
      WAIT_DATA: begin
        underrun_n = tick;
        // A read cannot be abandoned, so a restart requested during the
        // transaction takes effect when the data strobe retires it.
        if (flash_mem_readdatavalid) begin
          if (rst_pend || fetcher_reset) begin
            restart = 1'b1;
          end else begin
            word_n     = flash_mem_readdata;
            word_fwd_n = forward;
            state_n    = SLOT0;
          end
        end else if (fetcher_reset) begin
          rst_pend_n = 1'b1;
        end
      end
      SLOT0: begin
        if (fetcher_reset) begin
          restart = 1'b1;
        end else if (tick) begin
          audio_data_n  = word_fwd ? word[15:0] : word[31:16];
          audio_valid_n = 1'b1;
          state_n       = SLOT1;
        end
      end
      SLOT1: begin
        if (fetcher_reset) begin
          restart = 1'b1;
        end else if (tick) begin
          audio_data_n  = word_fwd ? word[31:16] : word[15:0];
          audio_valid_n = 1'b1;
          state_n       = REQ;
          if (word_fwd)
            addr_n = (flash_mem_address == LAST_ADDR) ? '0 : flash_mem_address + ADDR_ONE;
          else
            addr_n = (flash_mem_address == '0) ? LAST_ADDR : flash_mem_address - ADDR_ONE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (restart) begin
      addr_n     = forward ? '0 : LAST_ADDR;
      state_n    = REQ;
      cnt_n      = '0;
      word_n     = '0;
      rst_pend_n = 1'b0;
    end

    // Registered read strobe tracks the REQ state exactly.
    read_n = (state_n == REQ);
  end

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Scoreboard bench for flash_sample_fetcher: directed scenarios push the
// expected samples (with cycle spacing) and read addresses; a flash slave
// model and an output monitor pop and compare independently.
`timescale 1ns/1ps
module tb_flash_sample_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sample_freq_div = 32'd4;
  logic        pause = 1'b0;
  logic        forward = 1'b1;
  logic        fetcher_reset = 1'b0;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic        flash_mem_waitrequest = 1'b0;
  logic [31:0] flash_mem_readdata = '0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [15:0] audio_data;
  logic        audio_valid;
  logic        underrun;

  flash_sample_fetcher #(.ADDR_W(23), .LAST_ADDR(23'h7FFFF)) dut (
    .clk(clk), .rst(rst), .sample_freq_div(sample_freq_div), .pause(pause),
    .forward(forward), .fetcher_reset(fetcher_reset),
    .flash_mem_read(flash_mem_read), .flash_mem_address(flash_mem_address),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid),
    .audio_data(audio_data), .audio_valid(audio_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; int gap; } exp_t;
  exp_t        sample_q[$];
  logic [22:0] addr_q[$];
  int checks = 0;
  int errors = 0;
  int cyc;
  int last_valid = 0;
  int under_cnt = 0;
  int cfg_wait = 0;
  int cfg_lat = 1;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    case (a)
      23'h00000: mem_word = 32'hBBBB_AAAA;
      23'h00001: mem_word = 32'hDDDD_CCCC;
      23'h00002: mem_word = 32'h2B2B_2A2A;
      23'h00003: mem_word = 32'h3B3B_3A3A;
      23'h00004: mem_word = 32'h4B4B_4A4A;
      23'h00005: mem_word = 32'h5B5B_5A5A;
      23'h7FFFF: mem_word = 32'h1234_5678;
      23'h7FFFE: mem_word = 32'h9ABC_DEF0;
      default:   mem_word = 32'hE0E0_E0E0;
    endcase
  endfunction

  // Flash slave: waitrequest for cfg_wait cycles per request, data cfg_lat
  // cycles after acceptance.
  initial begin
    int          wait_left;
    int          pend_lat;
    logic        in_req;
    logic [22:0] req_addr, pend_addr, ea;
    wait_left = 0; pend_lat = 0; in_req = 1'b0; req_addr = '0; pend_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_req = 1'b0; pend_lat = 0;
        flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0;
      end else begin
        flash_mem_readdatavalid = 1'b0;
        if (pend_lat > 0) begin
          pend_lat--;
          if (pend_lat == 0) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem_word(pend_addr);
          end
        end
        if (flash_mem_read) begin
          if (!in_req) begin
            in_req = 1'b1; wait_left = cfg_wait; req_addr = flash_mem_address;
            check("one_outstanding", pend_lat, 0);
          end else begin
            check("addr_stable", flash_mem_address, req_addr);
          end
          if (wait_left > 0) begin
            flash_mem_waitrequest = 1'b1;
            wait_left--;
          end else begin
            flash_mem_waitrequest = 1'b0;
            in_req = 1'b0; pend_addr = req_addr; pend_lat = cfg_lat;
            if (addr_q.size() > 0) begin
              ea = addr_q.pop_front();
              check("read_addr", req_addr, ea);
            end
          end
        end else begin
          flash_mem_waitrequest = 1'b0;
        end
      end
    end
  end

  // Output monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (audio_valid) begin
          if (sample_q.size() > 0) begin
            e = sample_q.pop_front();
            check("audio_data", audio_data, e.data);
            check("valid_spacing", cyc - last_valid, e.gap);
          end
          last_valid = cyc;
        end
        if (underrun) under_cnt++;
      end
    end
  end

  task automatic exp_s(input logic [15:0] d, input int gap);
    exp_t e;
    e.data = d; e.gap = gap;
    sample_q.push_back(e);
  endtask

  task automatic exp_a(input logic [22:0] a);
    addr_q.push_back(a);
  endtask

  task automatic do_reset(input logic fwd, input logic [31:0] div);
    @(negedge clk);
    rst = 1'b1; forward = fwd; sample_freq_div = div; pause = 1'b0;
    fetcher_reset = 1'b0; cfg_wait = 0; cfg_lat = 1;
    sample_q.delete(); addr_q.delete(); under_cnt = 0; last_valid = 0;
    @(negedge clk);
    check("rst_read", flash_mem_read, 0);
    check("rst_address", flash_mem_address, 0);
    check("rst_audio_data", audio_data, 0);
    check("rst_audio_valid", audio_valid, 0);
    check("rst_underrun", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!audio_valid && t < 300) begin @(negedge clk); t++; end
    if (!audio_valid) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic finish_scn(input string name, input int exp_under);
    int t = 0;
    while ((sample_q.size() > 0 || addr_q.size() > 0) && t < 500) begin
      @(negedge clk); t++;
    end
    check({name, "_drain"}, sample_q.size() + addr_q.size(), 0);
    check({name, "_underruns"}, under_cnt, exp_under);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic forward playback, zero-wait flash.
    do_reset(1'b1, 32'd4);
    exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 4); exp_s(16'hBBBB, 4); exp_s(16'hCCCC, 4); exp_s(16'hDDDD, 4);
    finish_scn("basic", 0);

    // Backward from reset: word 0 upper-first, then wrap 0 -> 7FFFF -> 7FFFE.
    do_reset(1'b0, 32'd4);
    exp_a(23'h0); exp_a(23'h7FFFF); exp_a(23'h7FFFE);
    exp_s(16'hBBBB, 4); exp_s(16'hAAAA, 4); exp_s(16'h1234, 4);
    exp_s(16'h5678, 4); exp_s(16'h9ABC, 4); exp_s(16'hDEF0, 4);
    finish_scn("backward", 0);

    // fetcher_reset during the first read with forward=0 restarts at 7FFFF;
    // forward=1 before that word latches gives low-first order and a 0 wrap.
    do_reset(1'b0, 32'd4);
    exp_a(23'h0); exp_a(23'h7FFFF); exp_a(23'h0);
    exp_s(16'h5678, 7); exp_s(16'h1234, 4); exp_s(16'hAAAA, 4); exp_s(16'hBBBB, 4);
    wait_cyc(1); fetcher_reset = 1'b1;
    wait_cyc(2); fetcher_reset = 1'b0;
    wait_cyc(3); forward = 1'b1;
    finish_scn("fwd_wrap", 0);

    // fetcher_reset while word 5 is in WAIT_DATA: word 5 never plays.
    do_reset(1'b1, 32'd4);
    for (int a = 0; a <= 5; a++) exp_a(a[22:0]);
    exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 4); exp_s(16'hBBBB, 4); exp_s(16'hCCCC, 4); exp_s(16'hDDDD, 4);
    exp_s(16'h2A2A, 4); exp_s(16'h2B2B, 4); exp_s(16'h3A3A, 4); exp_s(16'h3B3B, 4);
    exp_s(16'h4A4A, 4); exp_s(16'h4B4B, 4); exp_s(16'hAAAA, 6); exp_s(16'hBBBB, 4);
    begin
      int t = 0;
      while (!(flash_mem_read && flash_mem_address == 23'h5) && t < 300) begin
        @(negedge clk); t++;
      end
      if (!(flash_mem_read && flash_mem_address == 23'h5)) check("wait_addr5_timeout", 1, 0);
      @(negedge clk); fetcher_reset = 1'b1;
      @(negedge clk); fetcher_reset = 1'b0;
    end
    finish_scn("reset_mid_read", 0);

    // Waitrequest 3 cycles, data 5 cycles after acceptance, div 4. The first
    // fetch spans cycles 1..9, which holds the ticks of cycles 3 and 7, so it
    // costs two underruns; later reads are zero-wait and play normally.
    do_reset(1'b1, 32'd4);
    cfg_wait = 3; cfg_lat = 5;
    exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 12); exp_s(16'hBBBB, 4); exp_s(16'hCCCC, 4); exp_s(16'hDDDD, 4);
    wait_valid("slow_first");
    cfg_wait = 0; cfg_lat = 1;
    finish_scn("slow_flash", 2);

    // Pause for 20 cycles in SLOT1 right after the first sample.
    do_reset(1'b1, 32'd4);
    exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 4); exp_s(16'hBBBB, 24); exp_s(16'hCCCC, 4); exp_s(16'hDDDD, 4);
    wait_valid("pause_first");
    pause = 1'b1;
    repeat (20) @(negedge clk);
    pause = 1'b0;
    finish_scn("pause", 0);

    // Divider 0 and 1 behave as 2; a 4-cycle fetch underruns once per word.
    for (int d = 0; d < 2; d++) begin
      do_reset(1'b1, d);
      exp_a(23'h0); exp_a(23'h1);
      exp_s(16'hAAAA, 4); exp_s(16'hBBBB, 2); exp_s(16'hCCCC, 4); exp_s(16'hDDDD, 2);
      finish_scn("div_small", 2);
    end

    // Divider drops from 100 to 3 while cnt = 50: tick on the next edge.
    do_reset(1'b1, 32'd100);
    exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 51); exp_s(16'hBBBB, 3); exp_s(16'hCCCC, 3);
    wait_cyc(50); sample_freq_div = 32'd3;
    finish_scn("div_change", 0);

    // fetcher_reset coinciding with the SLOT1 tick: reset wins, no sample.
    do_reset(1'b1, 32'd4);
    exp_a(23'h0); exp_a(23'h0); exp_a(23'h1);
    exp_s(16'hAAAA, 4); exp_s(16'hAAAA, 8); exp_s(16'hBBBB, 4);
    wait_cyc(7); fetcher_reset = 1'b1;
    wait_cyc(8); fetcher_reset = 1'b0;
    finish_scn("reset_on_tick", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
